// File: rtl/nmr_pkg.sv
// Shared types and helpers for the N-modular-redundant ALU: status encoding,
// alucont operation codes and a small popcount used by the per-bit voter.
package nmr_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_CRITICAL = 2'b10,
    ST_FAILED   = 2'b11
  } status_t;

  localparam logic [1:0] ALUCONT_AND = 2'b00;
  localparam logic [1:0] ALUCONT_OR  = 2'b01;
  localparam logic [1:0] ALUCONT_SUM = 2'b10;
  localparam logic [1:0] ALUCONT_SLT = 2'b11;

  // Widest supported replica set; vote counts therefore fit in 3 bits.
  localparam int MAX_REP = 7;

  function automatic logic [2:0] popcount(input logic [MAX_REP-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < MAX_REP; k++) n = n + {2'b00, v[k]};
    return n;
  endfunction

endpackage

// File: rtl/nmr_alu_lane.sv
// One combinational ALU replica: AND / OR / SUM / SLT with optional b inversion
// and carry-in (alucont[2]), used NREP times by nmr_alu.
module nmr_alu_lane
  import nmr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucont,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;

  assign b_eff = alucont[2] ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, alucont[2]};

  always_comb begin
    y = '0;
    case (alucont[1:0])
      ALUCONT_AND: y = a & b_eff;
      ALUCONT_OR:  y = a | b_eff;
      ALUCONT_SUM: y = sum;
      ALUCONT_SLT: y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
    endcase
  end

endmodule

// File: rtl/nmr_alu.sv
// NREP-way redundant ALU with per-bit majority vote over surviving replicas,
// sticky fault masks, fault counter and monotonic degradation status.
// Optional replica fault injection is enabled by defining NMR_FAULT_INJECT_EN.
module nmr_alu
  import nmr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREP  = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [2:0]              alucont,
`ifdef NMR_FAULT_INJECT_EN
  input  logic                    inj_en,
  input  logic [$clog2(NREP)-1:0] inj_rep,
  input  logic [WIDTH-1:0]        inj_mask,
`endif
  output logic                    valid_out,
  output logic [WIDTH-1:0]        result,
  output logic                    zero,
  output logic [1:0]              status,
  output logic [CNT_W-1:0]        fault_count,
  output logic [NREP-1:0]         rep_alive
);

  logic [WIDTH-1:0] lane_y    [NREP];
  logic [WIDTH-1:0] rep_y     [NREP];
  logic [WIDTH-1:0] mask_reg  [NREP];
  logic [WIDTH-1:0] mask_next [NREP];
  logic [WIDTH-1:0] clear     [NREP];
  logic [NREP-1:0]  alive_bits [WIDTH];
  logic [NREP-1:0]  ones_bits  [WIDTH];
  logic [NREP-1:0]  post_bits  [WIDTH];
  logic [WIDTH-1:0] voted, tie, post_low, post_two;
  logic [NREP-1:0]  rep_clear;

  logic             valid_out_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  status_t          state_reg, state_next, state_cand;
  logic             any_masked;

  genvar gi, gr;
  generate
    for (gr = 0; gr < NREP; gr++) begin : g_rep
      nmr_alu_lane #(.WIDTH(WIDTH)) u_lane (
        .a       (a),
        .b       (b),
        .alucont (alucont),
        .y       (lane_y[gr])
      );
`ifdef NMR_FAULT_INJECT_EN
      assign rep_y[gr] = lane_y[gr] ^ ((inj_en && int'(inj_rep) == gr) ? inj_mask : '0);
`else
      assign rep_y[gr] = lane_y[gr];
`endif
      assign mask_next[gr] = mask_reg[gr] & ~clear[gr];
      assign rep_clear[gr] = |clear[gr];
      assign rep_alive[gr] = &mask_reg[gr];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [2:0] alive_cnt, ones_cnt, post_cnt;
      for (gr = 0; gr < NREP; gr++) begin : g_tr
        assign alive_bits[gi][gr] = mask_reg[gr][gi];
        assign ones_bits[gi][gr]  = mask_reg[gr][gi] & rep_y[gr][gi];
        assign post_bits[gi][gr]  = mask_next[gr][gi];
        // Only decisive (non-tied) bits may blame a dissenting live replica.
        assign clear[gr][gi] = valid_in & ~tie[gi] & mask_reg[gr][gi] & (rep_y[gr][gi] ^ voted[gi]);
      end
      assign alive_cnt    = popcount(MAX_REP'(alive_bits[gi]));
      assign ones_cnt     = popcount(MAX_REP'(ones_bits[gi]));
      assign post_cnt     = popcount(MAX_REP'(post_bits[gi]));
      assign voted[gi]    = {ones_cnt, 1'b0} > {1'b0, alive_cnt};
      assign tie[gi]      = {ones_cnt, 1'b0} == {1'b0, alive_cnt};
      assign post_low[gi] = post_cnt <= 3'd1;
      assign post_two[gi] = post_cnt == 3'd2;
    end
  endgenerate

  always_comb begin
    any_masked = 1'b0;
    for (int r = 0; r < NREP; r++) begin
      if (mask_next[r] != '1) any_masked = 1'b1;
    end

    state_cand = ST_OK;
    if ((valid_in && |tie) || |post_low) state_cand = ST_FAILED;
    else if (|post_two)                  state_cand = ST_CRITICAL;
    else if (any_masked)                 state_cand = ST_DEGRADED;

    // Status only ever climbs; reset is the sole way back down.
    state_next = state_reg;
    if (state_cand > state_reg) state_next = state_cand;

    count_next = count_reg;
    if (|rep_clear && count_reg != '1) count_next = count_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      count_reg     <= '0;
      state_reg     <= ST_OK;
      for (int r = 0; r < NREP; r++) mask_reg[r] <= '1;
    end else begin
      valid_out_reg <= valid_in;
      if (valid_in) begin
        result_reg <= voted;
        zero_reg   <= (voted == '0);
      end
      count_reg <= count_next;
      state_reg <= state_next;
      for (int r = 0; r < NREP; r++) mask_reg[r] <= mask_next[r];
    end
  end

  assign valid_out   = valid_out_reg;
  assign result      = result_reg;
  assign zero        = zero_reg;
  assign status      = state_reg;
  assign fault_count = count_reg;

endmodule
